// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) arithmetic and the InvMixColumns FSM encoding.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  // Low byte of the field polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] RED_POLY = 8'h1B;

  // Circulant InvMixColumns matrix, indexed [row][column]
  localparam logic [0:3][0:3][7:0] IMC_COEF = {
    8'h0e, 8'h0b, 8'h0d, 8'h09,
    8'h09, 8'h0e, 8'h0b, 8'h0d,
    8'h0d, 8'h09, 8'h0e, 8'h0b,
    8'h0b, 8'h0d, 8'h09, 8'h0e
  };

  // FSM encoding, kept as plain constants so legacy tools can read it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Multiply by x, reducing when the top bit falls out
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? RED_POLY : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // MSB position of column idx inside the 128-bit state (column 0 is the top word)
  function automatic int col_msb(input logic [1:0] idx);
    return STATE_W - 1 - COL_W * int'(idx);
  endfunction

endpackage

// File: rtl/inv_mix_columns_if.sv
// Start/result bundle of the InvMixColumns engine.
interface inv_mix_columns_if;
  logic         En_IMC;
  logic [127:0] In_IMC;
  logic [127:0] Out_IMC;
  logic         Ry_IMC;
  logic         Busy_IMC;

  modport master (output En_IMC, output In_IMC,
                  input  Out_IMC, input Ry_IMC, input Busy_IMC);
  modport slave  (input  En_IMC, input In_IMC,
                  output Out_IMC, output Ry_IMC, output Busy_IMC);
endinterface

// File: rtl/imc_column.sv
// Combinational InvMixColumns of a single 32-bit column (row 0 in the top byte).
module imc_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a [4];

  // Split the column into bytes, row 0 first
  always_comb begin
    for (int r = 0; r < 4; r++) a[r] = col_i[COL_W-1-8*r -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign col_o[COL_W-1-8*gi -: 8] = gf_mul(a[0], IMC_COEF[gi][0]) ^
                                      gf_mul(a[1], IMC_COEF[gi][1]) ^
                                      gf_mul(a[2], IMC_COEF[gi][2]) ^
                                      gf_mul(a[3], IMC_COEF[gi][3]);
  end

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, fixed latency.
module inv_mix_columns
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic Clk,
  input  logic Rst,
  inv_mix_columns_if.slave bus
);

  logic [1:0]         state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic               ry_q, ry_d;
  logic               busy_q, busy_d;

  logic [COL_W-1:0]   col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];
  logic [STATE_W-1:0] work_mixed;
  logic               last_step;

  // Pick the columns being transformed this cycle, starting at the counter
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      col_in[g] = work_q[col_msb(cnt_q + 2'(g)) -: COL_W];
  end

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    imc_column u_col (.col_i(col_in[gi]), .col_o(col_out[gi]));
  end

  // Merge the transformed columns back into the work state
  always_comb begin
    work_mixed = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      work_mixed[col_msb(cnt_q + 2'(g)) -: COL_W] = col_out[g];
  end

  // This step finishes column 3 when counter plus step reaches four
  assign last_step = ({1'b0, cnt_q} + 3'(COLS_PER_CYCLE)) == 3'd4;

  // Next-state logic: DONE accepts exactly like IDLE so requests can run back-to-back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    ry_d    = ry_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        ry_d = 1'b0;
        if (bus.En_IMC) begin
          work_d  = bus.In_IMC;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        work_d = work_mixed;
        cnt_d  = cnt_q + 2'(COLS_PER_CYCLE);
        if (last_step) begin
          out_d   = work_mixed;
          ry_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      out_q   <= '0;
      ry_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      ry_q    <= ry_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Out_IMC  = out_q;
  assign bus.Ry_IMC   = ry_q;
  assign bus.Busy_IMC = busy_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench: three engines (1, 2 and 4 columns per cycle) against a GF reference model.
module tb_inv_mix_columns;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic         en_v   [3];
  logic [127:0] in_v   [3];
  logic [127:0] out_v  [3];
  logic         ry_v   [3];
  logic         busy_v [3];
  logic [127:0] last_exp [3];

  localparam logic [127:0] VA = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] EA = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VB = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] EB = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  always #5 clk = ~clk;

  inv_mix_columns_if ifc0 ();
  inv_mix_columns_if ifc1 ();
  inv_mix_columns_if ifc2 ();

  assign ifc0.En_IMC = en_v[0];
  assign ifc0.In_IMC = in_v[0];
  assign ifc1.En_IMC = en_v[1];
  assign ifc1.In_IMC = in_v[1];
  assign ifc2.En_IMC = en_v[2];
  assign ifc2.In_IMC = in_v[2];
  assign out_v[0] = ifc0.Out_IMC;
  assign out_v[1] = ifc1.Out_IMC;
  assign out_v[2] = ifc2.Out_IMC;
  assign ry_v[0] = ifc0.Ry_IMC;
  assign ry_v[1] = ifc1.Ry_IMC;
  assign ry_v[2] = ifc2.Ry_IMC;
  assign busy_v[0] = ifc0.Busy_IMC;
  assign busy_v[1] = ifc1.Busy_IMC;
  assign busy_v[2] = ifc2.Busy_IMC;

  inv_mix_columns #(.COLS_PER_CYCLE(1)) dut_p1 (.Clk(clk), .Rst(rst_n), .bus(ifc0));
  inv_mix_columns #(.COLS_PER_CYCLE(2)) dut_p2 (.Clk(clk), .Rst(rst_n), .bus(ifc1));
  inv_mix_columns #(.COLS_PER_CYCLE(4)) dut_p4 (.Clk(clk), .Rst(rst_n), .bus(ifc2));

  // Reference GF(2^8) multiply: carry-less product then long division by 0x11B
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int bt = 14; bt >= 8; bt--) if (p[bt]) p = p ^ (16'h011B << (bt - 8));
    return p[7:0];
  endfunction

  // Reference InvMixColumns: circulant matrix with first row 0e 0b 0d 09
  function automatic logic [127:0] ref_imc(input logic [127:0] s);
    logic [7:0]   base [4];
    logic [127:0] r;
    logic [7:0]   acc;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ ref_gmul(base[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic int lat_of(input int i);
    return 4 / (1 << i);
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request now; returns #1 after the completion edge (Ry cycle)
  task automatic run_op(input int i, input logic [127:0] d);
    logic [127:0] exp;
    int lat;
    exp = ref_imc(d);
    lat = lat_of(i);
    en_v[i] = 1'b1;
    in_v[i] = d;
    step();
    en_v[i] = 1'b0;
    in_v[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    check_val($sformatf("busy_accept_p%0d", 1 << i), 128'(busy_v[i]), 128'd1);
    for (int c = 1; c <= lat; c++) begin
      step();
      check_val($sformatf("ry_e%0d_p%0d", c, 1 << i), 128'(ry_v[i]), 128'(c == lat));
      check_val($sformatf("busy_e%0d_p%0d", c, 1 << i), 128'(busy_v[i]), 128'(c != lat));
    end
    check_val($sformatf("out_p%0d", 1 << i), out_v[i], exp);
    last_exp[i] = exp;
    $display("op p%0d in=%h out=%h exp=%h", 1 << i, d, out_v[i], exp);
  endtask

  // One cycle after a completion with no new request: pulse gone, idle
  task automatic check_quiet(input int i, input string tag);
    step();
    check_val($sformatf("%s_ry_p%0d", tag, 1 << i), 128'(ry_v[i]), 128'd0);
    check_val($sformatf("%s_busy_p%0d", tag, 1 << i), 128'(busy_v[i]), 128'd0);
    check_val($sformatf("%s_out_p%0d", tag, 1 << i), out_v[i], last_exp[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      en_v[i] = 1'b0;
      in_v[i] = '0;
      last_exp[i] = '0;
    end
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst_out_p%0d", 1 << i), out_v[i], 128'd0);
      check_val($sformatf("rst_ry_p%0d", 1 << i), 128'(ry_v[i]), 128'd0);
      check_val($sformatf("rst_busy_p%0d", 1 << i), 128'(busy_v[i]), 128'd0);
    end
    rst_n = 1'b1;
    step();

    // Known vector, then back-to-back request during the Ry cycle
    for (int i = 0; i < 3; i++) begin
      run_op(i, VA);
      check_val($sformatf("vecA_p%0d", 1 << i), out_v[i], EA);
      run_op(i, VB);
      check_val($sformatf("vecB_p%0d", 1 << i), out_v[i], EB);
      check_quiet(i, "after_b2b");
    end

    // Request raised on BUSY edge 2 must be ignored
    en_v[0] = 1'b1; in_v[0] = VA;
    step();
    en_v[0] = 1'b0;
    step();
    en_v[0] = 1'b1; in_v[0] = {128{1'b1}};
    step();
    en_v[0] = 1'b0;
    step();
    check_val("ign_ry_e3", 128'(ry_v[0]), 128'd0);
    step();
    check_val("ign_ry_e4", 128'(ry_v[0]), 128'd1);
    check_val("ign_out", out_v[0], EA);
    last_exp[0] = EA;
    $display("op p1 ignored-request in=%h out=%h", VA, out_v[0]);
    for (int n = 0; n < 6; n++) check_quiet(0, "ign_tail");

    // Reset on BUSY edge 2 aborts the operation
    en_v[0] = 1'b1; in_v[0] = VB;
    step();
    en_v[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check_val("abort_out", out_v[0], 128'd0);
    check_val("abort_ry", 128'(ry_v[0]), 128'd0);
    check_val("abort_busy", 128'(busy_v[0]), 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    $display("op p1 reset-abort out=%h", out_v[0]);
    for (int n = 0; n < 8; n++) begin
      step();
      check_val($sformatf("abort_ry_c%0d", n), 128'(ry_v[0]), 128'd0);
    end

    // Randomized operations, sometimes back-to-back
    for (int n = 0; n < 30; n++) begin
      int i;
      i = int'($urandom_range(0, 2));
      run_op(i, {$urandom(), $urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 1) == 1) run_op(i, {$urandom(), $urandom(), $urandom(), $urandom()});
      check_quiet(i, "rnd");
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) step();
    end

    // Long idle: outputs hold, no pulses
    for (int n = 0; n < 10; n++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        check_val($sformatf("hold_out_p%0d", 1 << i), out_v[i], last_exp[i]);
        check_val($sformatf("hold_ry_p%0d", 1 << i), 128'(ry_v[i]), 128'd0);
        check_val($sformatf("hold_busy_p%0d", 1 << i), 128'(busy_v[i]), 128'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns.md
INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: COLS_PER_CYCLE, default 1, meaning columns transformed per clock; legal values are 1, 2 and 4.
REQ-003 Port: Clk, input, 1, rising-edge clock.
REQ-004 Port: Rst, input, 1, synchronous active-low reset.
REQ-005 Port: En_IMC, input, 1, start request, sampled only when the block accepts.
REQ-006 Port: In_IMC, input, 128, state to transform, captured on the accepting edge.
REQ-007 Port: Out_IMC, output reg, 128, transformed state.
REQ-008 Port: Ry_IMC, output reg, 1, one-cycle completion pulse.
REQ-009 Port: Busy_IMC, output reg, 1, high while an operation is in progress.

Function
REQ-010 The block SHALL compute AES InvMixColumns over GF(2^8) with reduction polynomial 0x11B.
- Coefficient matrix rows: {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
REQ-011 Byte mapping SHALL be as follows:
- Column c occupies In_IMC[127-32c -: 32].
- Row 0 is the most significant byte of each column.
- Out_IMC uses the same mapping.
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 IDLE with En_IMC=1 SHALL:
- capture In_IMC into the work register;
- clear the column counter;
- set Busy_IMC=1;
- go to BUSY.
REQ-014 IDLE with En_IMC=0 SHALL hold all registers.
REQ-015 Each BUSY edge SHALL:
- replace COLS_PER_CYCLE columns of the work register, starting at column counter;
- advance the counter by COLS_PER_CYCLE.
REQ-016 On the edge that completes column 3, the block SHALL:
- load the finished state into Out_IMC;
- set Ry_IMC=1 and Busy_IMC=0;
- go to DONE.
REQ-017 Latency SHALL be fixed: if edge k accepts, Ry_IMC rises on edge k+4/COLS_PER_CYCLE and falls on the following edge.
REQ-018 Ry_IMC SHALL be high only in DONE, exactly one cycle per accepted request.
REQ-019 DONE SHALL behave as IDLE for acceptance:
- En_IMC=1 in DONE starts a new operation, back-to-back, with no idle cycle;
- otherwise the block returns to IDLE.
REQ-020 En_IMC during BUSY SHALL be ignored:
- In_IMC is not captured;
- the request is not queued.
REQ-021 Out_IMC SHALL change only on completion edges and on reset, and SHALL hold between operations.
REQ-022 The column counter SHALL be 2 bits and SHALL wrap to 0 at completion.

Reset
REQ-023 When Rst=0 at a rising edge, the block SHALL set:
- state=IDLE;
- Out_IMC=0, Ry_IMC=0, Busy_IMC=0;
- work register=0, counter=0.
REQ-024 Reset SHALL take priority over En_IMC.
REQ-025 Reset during BUSY or DONE SHALL abort the operation; no Ry_IMC pulse follows for the aborted request.

Structure
REQ-026 Shared package aes_pkg SHALL hold:
- state width (128) and column width (32) constants;
- reduction constant 0x1B;
- the xtime/GF-multiply function;
- the InvMixColumns coefficient constants;
- the FSM state encoding.
REQ-027 The single-column transform SHALL be a combinational sub-module imc_column (32-bit in, 32-bit out), instantiated COLS_PER_CYCLE times.
REQ-028 The top level SHALL contain only the FSM, the counter, the work register and the column select/merge.

Verification
REQ-029 Basic vector, COLS_PER_CYCLE=1:
- stimulus: In=8e4da1bc_9fdc589d_01010101_c6c6c6c6, En for 1 cycle;
- response: Ry exactly one cycle, 4 edges after acceptance; Out=db135345_f20a225c_01010101_c6c6c6c6.
REQ-030 Back-to-back:
- stimulus: En=1 during the Ry cycle with In=d5d5d7d6_4d7ebdf8_00000000_ffffffff;
- response: accepted immediately; second Ry 4 edges later; Out=d4d4d4d5_2d26314c_00000000_ffffffff.
REQ-031 Ignored request:
- stimulus: En=1 with In=all-ones on BUSY edge 2;
- response: result from REQ-029 unchanged; single Ry pulse; no extra operation.
REQ-032 Reset mid-operation:
- stimulus: Rst=0 on BUSY edge 2;
- response: next edge Out=0, Ry=0, Busy=0; no Ry for the following 8 cycles.
REQ-033 COLS_PER_CYCLE=4 and =2:
- stimulus: REQ-029 vectors;
- response: identical Out; Ry on edge k+1 and k+2 respectively.
REQ-034 Idle hold:
- stimulus: En=0 for 10 cycles after completion;
- response: Out holds its last value; Ry=0; Busy=0.
